fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 6, queue capacity in instructions (even, >= 4).
REQ-002 SHALL have parameter RESET_PC, default 30'd0, fetch address after reset.
REQ-003 SHALL have parameter NOOP_OP, default 5'd0, opcode inserted in invalid output slots.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pc_fetch  output  30  word address of the pair presented to the registered instruction memory.
REQ-007 SHALL have port imem_instr0  input  32  memory word at the pc_fetch value from the previous cycle.
REQ-008 SHALL have port imem_instr1  input  32  memory word at that address + 1.
REQ-009 SHALL have port consume  input  2  number of instructions decode accepts this cycle, 0..2; 3 treated as 2.
REQ-010 SHALL have port flush  input  1  taken-branch redirect from writeback.
REQ-011 SHALL have port flush_addr  input  30  redirect target word address.
REQ-012 SHALL have port halt  input  1  halt reached writeback.
REQ-013 SHALL have port instr0_out  output  32  oldest queued instruction.
REQ-014 SHALL have port instr1_out  output  32  second-oldest queued instruction.
REQ-015 SHALL have port valid0  output  1  instr0_out holds a real instruction.
REQ-016 SHALL have port valid1  output  1  instr1_out holds a real instruction.

Function
REQ-017 SHALL hold a circular queue of DEPTH 32-bit entries: head pointer, tail pointer, count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-018 SHALL keep a flag inflight, set on the edge following a fetch request.
REQ-019 SHALL keep a state machine with states RUN and HALTED.
REQ-020 SHALL issue a request (req) when state = RUN, halt = 0, flush = 0, and count + 2*inflight <= DEPTH-2, using registered values only.
REQ-021 SHALL, on an edge with req = 1, advance pc_fetch by 2, wrapping modulo 2^30; otherwise hold pc_fetch.
REQ-022 SHALL, on an edge with inflight = 1 and flush = 0, write imem_instr0 then imem_instr1 at tail and tail+1 and add 2 to count.
REQ-023 SHALL pop n = min(consume, count) entries from head per edge; it SHALL ignore any consume in excess of count.
REQ-024 SHALL apply push and pop on the same edge with net count change +2-n; the req rule guarantees no overflow.
REQ-025 SHALL drive valid0 = (count >= 1) and valid1 = (count >= 2) combinationally from registers.
REQ-026 SHALL drive an invalid slot as {NOOP_OP, 27'd0}.
REQ-027 SHALL, on an edge with flush = 1, set count, head, tail and inflight to 0, load pc_fetch with flush_addr, and enter RUN.
REQ-028 SHALL, on a flush edge, discard the in-flight response and ignore consume.
REQ-029 SHALL give flush priority over halt when both are asserted on the same edge.
REQ-030 SHALL accept an odd flush_addr; the fetched pair is then flush_addr and flush_addr+1.
REQ-031 SHALL enter HALTED on an edge with halt = 1 and flush = 0.
REQ-032 SHALL, in HALTED, issue no requests, still capture a pending inflight response, and still allow pops.
REQ-033 SHALL leave HALTED only on flush or reset.
REQ-034 SHALL sustain two instructions per cycle in steady state when DEPTH >= 6 and consume = 2 every cycle.

Reset
REQ-035 SHALL, while rst = 0, asynchronously force pc_fetch = RESET_PC, count = 0, head = tail = 0, inflight = 0, state = RUN.
REQ-036 SHALL, during reset, drive valid0 = valid1 = 0 and both instruction outputs to {NOOP_OP, 27'd0}.
REQ-037 SHALL issue its first request on the first rising edge after rst deasserts.
REQ-038 SHALL abort all operation immediately on reset asserted mid-operation, with no partial push or pop.

Verification
REQ-039 Reset release, consume = 0, memory word[a] = a: edge1 pc 0->2; edge2 queue {0,1}, pc 4; edge3 count 4; edge4 count 6 (all at DEPTH 6); valid0 = valid1 = 1, instr0_out = 0; then no further requests, pc holds 6.
REQ-040 consume = 2 every cycle after fill: outputs sequence 0/1, 2/3, 4/5 ... with no cycle where valid1 = 0 after the first fill.
REQ-041 count = 1 with consume = 2: exactly one entry popped, count never negative, valid1 = 0 until the next push.
REQ-042 flush_addr = 0x101 asserted while inflight = 1 and count = 4: next cycle count = 0 and pc_fetch = 0x101; the stale response is dropped; the following edge requests 0x101 and the queue later holds {0x101, 0x102}.
REQ-043 halt and flush asserted together: state = RUN and pc_fetch = flush_addr; halt alone: no requests, queue drains via consume, pc frozen.
REQ-044 rst pulsed low mid-stream with count = 5: outputs invalid within the same cycle, pc_fetch = RESET_PC, and refill restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: requests instruction pairs from a registered instruction memory,
// buffers them in a circular queue and presents the two oldest to decode.
module fetch_queue #(
    parameter int          DEPTH    = 6,
    parameter logic [29:0] RESET_PC = 30'd0,
    parameter logic [4:0]  NOOP_OP  = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] pc_fetch,
    input  logic [31:0] imem_instr0,
    input  logic [31:0] imem_instr1,
    input  logic [1:0]  consume,
    input  logic        flush,
    input  logic [29:0] flush_addr,
    input  logic        halt,
    output logic [31:0] instr0_out,
    output logic [31:0] instr1_out,
    output logic        valid0,
    output logic        valid1
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int LIMIT_I = DEPTH - 2;
    localparam int DEPTH_I = DEPTH;

    localparam logic [CNT_W:0]   LIMIT     = LIMIT_I[CNT_W:0];
    localparam logic [PTR_W:0]   DEPTH_P   = DEPTH_I[PTR_W:0];
    localparam logic [PTR_W:0]   ONE_P     = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   TWO_P     = {{(PTR_W-1){1'b0}}, 2'd2};
    localparam logic [CNT_W-1:0] TWO_C     = {{(CNT_W-2){1'b0}}, 2'd2};
    localparam logic [31:0]      NOOP_WORD = {NOOP_OP, 27'd0};

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  head, tail, head_next, tail_next, head_plus1, tail_plus1;
    logic [CNT_W-1:0]  count, count_next, pop_c;
    logic [CNT_W:0]    occupancy;
    logic [PTR_W:0]    pop_p;
    logic [1:0]        consume_eff, pop_n;
    logic [29:0]       pc_next;
    logic              inflight, req, push;
    logic [31:0]       entries [DEPTH];

    // Pointer increment that wraps at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [PTR_W:0]   k);
        logic [PTR_W:0] s;
        s = {1'b0, p} + k;
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PTR_W-1:0];
    endfunction

    // Request decision and pop amount, derived from registered occupancy only.
    always_comb begin
        consume_eff = consume[1] ? 2'd2 : consume;
        occupancy   = {1'b0, count} + {{(CNT_W-1){1'b0}}, inflight, 1'b0};
        req         = (state == RUN) && !halt && !flush && (occupancy <= LIMIT);
        push        = inflight && !flush;
        if (flush)
            pop_n = 2'd0;
        else if ({{(CNT_W-2){1'b0}}, consume_eff} > count)
            pop_n = count[1:0];
        else
            pop_n = consume_eff;
        pop_c = {{(CNT_W-2){1'b0}}, pop_n};
        pop_p = {{(PTR_W-1){1'b0}}, pop_n};
    end

    // Next pointers, count and fetch address; flush clears everything and redirects.
    always_comb begin
        tail_plus1 = ptr_add(tail, ONE_P);
        head_plus1 = ptr_add(head, ONE_P);
        head_next  = ptr_add(head, pop_p);
        tail_next  = push ? ptr_add(tail, TWO_P) : tail;
        count_next = count + (push ? TWO_C : '0) - pop_c;
        pc_next    = req ? pc_fetch + 30'd2 : pc_fetch;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            pc_next    = flush_addr;
        end
    end

    // Run/halt next state: flush always restarts fetching, halt parks it.
    always_comb begin
        state_next = state;
        if (flush)
            state_next = RUN;
        else if (halt)
            state_next = HALTED;
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            pc_fetch <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            pc_fetch <= pc_next;
            head     <= head_next;
            tail     <= tail_next;
            count    <= count_next;
            inflight <= req;
        end
    end

    // Queue storage: the returning pair lands at tail and tail+1.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail]       <= imem_instr0;
            entries[tail_plus1] <= imem_instr1;
        end
    end

    // Present the two oldest entries, substituting no-ops for empty slots.
    always_comb begin
        valid0     = (count != '0);
        valid1     = (count >= TWO_C);
        instr0_out = valid0 ? entries[head]       : NOOP_WORD;
        instr1_out = valid1 ? entries[head_plus1] : NOOP_WORD;
    end

endmodule
